onchip_ram_pipelined: RTL and testbench



---
 rtl/onchip_ram_pipelined.sv | 91 +++++++++
 tb/tb_onchip_ram_pipelined.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_ram_pipelined.sv
// onchip_ram_pipelined: Avalon-MM single-port RAM with 1/2-cycle pipelined reads and optional clear-on-reset.
module onchip_ram_pipelined #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    chipselect,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   writedata,
    input  logic                    clken,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest,
    output logic                    init_done
);
    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic {CLEAR, READY} state_t;
    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

    state_t                 state, state_n;
    logic [ADDR_WIDTH-1:0]  cnt, cnt_n, waddr;
    logic [DATA_WIDTH-1:0]  mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0]  wdata, d1;
    logic [NB-1:0]          be;
    logic                   clearing, acc, acc_rd, we, v1;

    always_comb begin
        state_n = (state == CLEAR && cnt == '1) ? READY : state;
        cnt_n   = (state == CLEAR) ? cnt + 1'b1 : cnt;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= RST_STATE;
            cnt       <= '0;
            init_done <= (CLEAR_ON_RESET == 0);
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            init_done <= (state_n == READY);
        end

    assign waitrequest = (state != READY) | ~clken;
    assign acc         = chipselect & (read | write) & ~waitrequest;
    assign acc_rd      = acc & read & ~write;

    // The clear sequencer borrows the single write port, ignoring clken
    assign clearing = (state == CLEAR);
    assign we       = clearing | (acc & write);
    assign waddr    = clearing ? cnt : address;
    assign wdata    = clearing ? '0 : writedata;
    assign be       = clearing ? '1 : byteenable;

    always_ff @(posedge clk)
        for (int i = 0; i < NB; i++)
            if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else if (clken) begin
            v1 <= acc_rd;
            if (acc_rd) d1 <= mem[address];
        end

    if (READ_LATENCY == 2) begin : g_rl2
        logic                  v2;
        logic [DATA_WIDTH-1:0] d2;
        always_ff @(posedge clk or posedge reset)
            if (reset) begin
                v2 <= 1'b0;
                d2 <= '0;
            end else if (clken) begin
                v2 <= v1;
                if (v1) d2 <= d1;
            end
        assign readdatavalid = v2 & clken;
        assign readdata      = d2;
    end else begin : g_rl1
        assign readdatavalid = v1 & clken;
        assign readdata      = d1;
    end
endmodule

// File: tb/tb_onchip_ram_pipelined.sv
// tb_onchip_ram_pipelined: drives 1-cycle, 2-cycle and no-clear instances against a queue-based reference model.
module tb_onchip_ram_pipelined;
    typedef struct { logic [31:0] d; int k; } rsp_t;
    typedef struct { logic [3:0] a; logic [31:0] prior; logic [31:0] d; logic [3:0] be; logic [31:0] exp; } vec_t;

    logic clk = 0, reset = 0, cs = 0, rd = 0, wr = 0, clken = 1;
    logic [3:0]  addr = 0, be = 0;
    logic [31:0] wdata = 0;
    logic [31:0] rdata0, rdata1, rdata2;
    logic rdv0, rdv1, rdv2, wq0, wq1, wq2, id0, id1, id2;

    int total = 0, bad = 0, cyc = 0;
    logic [31:0] mem_m [16];
    bit   rdy = 0;
    int   clr = 16;
    rsp_t q1[$], q2[$];
    int   p1c[$], p2c[$];
    logic [31:0] p1d[$], p2d[$];
    vec_t tv [5];

    onchip_ram_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .CLEAR_ON_RESET(0)) u0 (
        .clk(clk), .reset(reset), .chipselect(cs), .address(addr), .byteenable(be), .read(rd), .write(wr),
        .writedata(wdata), .clken(clken), .readdata(rdata0), .readdatavalid(rdv0), .waitrequest(wq0), .init_done(id0));
    onchip_ram_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u1 (
        .clk(clk), .reset(reset), .chipselect(cs), .address(addr), .byteenable(be), .read(rd), .write(wr),
        .writedata(wdata), .clken(clken), .readdata(rdata1), .readdatavalid(rdv1), .waitrequest(wq1), .init_done(id1));
    onchip_ram_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u2 (
        .clk(clk), .reset(reset), .chipselect(cs), .address(addr), .byteenable(be), .read(rd), .write(wr),
        .writedata(wdata), .clken(clken), .readdata(rdata2), .readdatavalid(rdv2), .waitrequest(wq2), .init_done(id2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: a read is answered once READ_LATENCY-1 clock-enabled edges have passed since acceptance
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy = 0;
            clr = 16;
            q1.delete();
            q2.delete();
        end else if (!rdy) begin
            clr--;
            if (clr == 0) begin
                rdy = 1;
                foreach (mem_m[i]) mem_m[i] = 0;
            end
        end else if (clken) begin
            if (q1.size() > 0 && q1[0].k == 0) void'(q1.pop_front());
            foreach (q1[i]) q1[i].k++;
            if (q2.size() > 0 && q2[0].k == 1) void'(q2.pop_front());
            foreach (q2[i]) q2[i].k++;
            if (cs && rd && !wr) begin
                q1.push_back('{d: mem_m[addr], k: 0});
                q2.push_back('{d: mem_m[addr], k: 0});
            end
            if (cs && wr)
                for (int b = 0; b < 4; b++) if (be[b]) mem_m[addr][8*b +: 8] = wdata[8*b +: 8];
        end
    end

    always @(negedge clk) begin : monitor
        bit e1, e2;
        if (reset) begin
            chk("rst_rdata1", rdata1, 0);
            chk("rst_rdata2", rdata2, 0);
            chk("rst_rdv1", rdv1, 0);
            chk("rst_rdv2", rdv2, 0);
            chk("rst_wait1", wq1, 1);
            chk("rst_init1", id1, 0);
            chk("rst_init0", id0, 1);
        end else begin
            chk("wait1", wq1, !rdy || !clken);
            chk("wait2", wq2, !rdy || !clken);
            chk("wait0", wq0, !clken);
            chk("init1", id1, rdy);
            chk("init2", id2, rdy);
            chk("init0", id0, 1);
            e1 = clken && q1.size() > 0 && q1[0].k == 0;
            e2 = clken && q2.size() > 0 && q2[0].k == 1;
            chk("rdv1", rdv1, e1);
            chk("rdv2", rdv2, e2);
            if (e1) chk("data1", rdata1, q1[0].d);
            if (e2) chk("data2", rdata2, q2[0].d);
            if (rdv1) begin p1c.push_back(cyc); p1d.push_back(rdata1); end
            if (rdv2) begin p2c.push_back(cyc); p2d.push_back(rdata2); end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic idle();
        cs = 0; rd = 0; wr = 0;
    endtask

    task automatic clrp();
        p1c.delete(); p1d.delete(); p2c.delete(); p2d.delete();
    endtask

    task automatic pulse_reset();
        reset = 1;
        tick(2);
        reset = 0;
    endtask

    task automatic count_clear(input string nm);
        int n1 = 0, n2 = 0;
        repeat (30) begin
            @(negedge clk);
            if (wq1) n1++;
            if (wq2) n2++;
        end
        tick();
        chk(nm, n1, 16);
        chk(nm, n2, 16);
        chk(nm, id1, 1);
    endtask

    task automatic wr_word(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        cs = 1; wr = 1; rd = 0; addr = a; wdata = d; be = b;
        tick();
        idle();
    endtask

    task automatic rd_word(input logic [3:0] a, input logic [31:0] exp, input string nm);
        clrp();
        cs = 1; rd = 1; wr = 0; addr = a;
        tick();
        idle();
        tick(4);
        chk(nm, p1d.size(), 1);
        chk(nm, p2d.size(), 1);
        chk(nm, p1d.size() == 1 ? p1d[0] : ~exp, exp);
        chk(nm, p2d.size() == 1 ? p2d[0] : ~exp, exp);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int a0, rc;
        tv[0] = '{a: 4'd5,  prior: 32'h11223344, d: 32'hDEADBEEF, be: 4'b0101, exp: 32'h11AD33EF};
        tv[1] = '{a: 4'd2,  prior: 32'hFFFFFFFF, d: 32'h00000000, be: 4'b1000, exp: 32'h00FFFFFF};
        tv[2] = '{a: 4'd9,  prior: 32'h12345678, d: 32'hCAFEF00D, be: 4'b0000, exp: 32'h12345678};
        tv[3] = '{a: 4'd15, prior: 32'h00000000, d: 32'hA1B2C3D4, be: 4'b1111, exp: 32'hA1B2C3D4};
        tv[4] = '{a: 4'd0,  prior: 32'hAAAAAAAA, d: 32'h55555555, be: 4'b0110, exp: 32'hAA5555AA};
        #1;
        pulse_reset();
        count_clear("clear_len");
        for (int i = 0; i < 16; i++) rd_word(4'(i), 32'h0, "clear_zero");

        foreach (tv[i]) begin
            wr_word(tv[i].a, tv[i].prior, 4'hF);
            wr_word(tv[i].a, tv[i].d, tv[i].be);
            rd_word(tv[i].a, tv[i].exp, "byte_en");
        end

        for (int i = 0; i < 3; i++) wr_word(4'(i), 32'h0B0B0000 + i, 4'hF);
        clrp();
        cs = 1; rd = 1; wr = 0; addr = 0;
        tick();
        a0 = cyc;
        addr = 1;
        tick();
        addr = 2;
        tick();
        idle();
        tick(4);
        chk("b2b_count2", p2c.size(), 3);
        chk("b2b_count1", p1c.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("b2b_cyc2", p2c.size() == 3 ? p2c[i] : -1, a0 + 1 + i);
            chk("b2b_cyc1", p1c.size() == 3 ? p1c[i] : -1, a0 + i);
            chk("b2b_data2", p2d.size() == 3 ? p2d[i] : 0, 32'h0B0B0000 + i);
        end

        wr_word(7, 32'h7777ABCD, 4'hF);
        clrp();
        cs = 1; rd = 1; addr = 7;
        tick();
        idle();
        clken = 0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_wait1", wq1, 1);
            chk("stall_rdv1", rdv1, 0);
            @(posedge clk);
            #1;
        end
        clken = 1;
        rc = cyc;
        tick(4);
        chk("stall_pulses1", p1c.size(), 1);
        chk("stall_cyc1", p1c.size() == 1 ? p1c[0] : -1, rc);
        chk("stall_data1", p1d.size() == 1 ? p1d[0] : 0, 32'h7777ABCD);
        chk("stall_cyc2", p2c.size() == 1 ? p2c[0] : -1, rc + 1);

        cs = 1; wr = 1; rd = 0; addr = 3; wdata = 32'hA5A5A5A5; be = 4'hF;
        tick();
        clrp();
        wr = 0; rd = 1;
        tick();
        idle();
        tick(4);
        chk("wr_then_rd", p1d.size() == 1 ? p1d[0] : 0, 32'hA5A5A5A5);
        chk("wr_then_rd2", p2d.size() == 1 ? p2d[0] : 0, 32'hA5A5A5A5);

        clrp();
        cs = 1; rd = 1; wr = 1; addr = 4; wdata = 32'h600DF00D; be = 4'hF;
        tick();
        idle();
        tick(4);
        chk("rw_no_rdv1", p1c.size(), 0);
        chk("rw_no_rdv2", p2c.size(), 0);
        rd_word(4, 32'h600DF00D, "rw_write_lands");

        pulse_reset();
        tick(7);
        pulse_reset();
        count_clear("clear_restart");
        rd_word(4, 32'h0, "restart_zero");

        clrp();
        cs = 1; rd = 1; wr = 0; addr = 5;
        tick();
        idle();
        reset = 1;
        tick(2);
        reset = 0;
        count_clear("rst_read_clear");
        tick(3);
        chk("rst_flush1", p1c.size(), 0);
        chk("rst_flush2", p2c.size(), 0);

        for (int i = 0; i < 600; i++) begin
            cs = $urandom_range(0, 3) != 0;
            rd = 1'($urandom);
            wr = 1'($urandom);
            addr = 4'($urandom);
            be = 4'($urandom);
            wdata = $urandom;
            clken = $urandom_range(0, 4) != 0;
            tick();
        end
        idle();
        clken = 1;
        tick(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
